branchunit: RTL and testbench

Program-counter and condition-flag stage directly downstream of instruction control decode. Consumes the decoded flag-enable, jump and jump-offset signals plus the ALU's raw NZCV results. Holds the architectural flags register, evaluates the 4-bit jump condition against it, and owns the PC register. Produces the next fetch address and a one-cycle flush pulse on every taken jump.

---
 rtl/branchunit_pkg.sv | 53 +++++
 rtl/branchunit_if.sv | 34 +++
 rtl/branchunit_condeval.sv | 33 +++
 rtl/branchunit.sv | 110 +++++++++++
 tb/tb_branchunit.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/branchunit_pkg.sv
// Shared types for the branch unit: condition codes, the NZCV flag record
// and the flag-merge helper used on every accepted instruction.
package branchunit_pkg;

    typedef enum logic [3:0] {
        COND_AL  = 4'd0,
        COND_NV  = 4'd1,
        COND_EQ  = 4'd2,
        COND_NE  = 4'd3,
        COND_CS  = 4'd4,
        COND_CC  = 4'd5,
        COND_MI  = 4'd6,
        COND_PL  = 4'd7,
        COND_GE  = 4'd8,
        COND_LT  = 4'd9,
        COND_GT  = 4'd10,
        COND_LE  = 4'd11,
        COND_HI  = 4'd12,
        COND_LS  = 4'd13,
        COND_JSR = 4'd14,
        COND_RET = 4'd15
    } cond_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    // N,Z and C,V pairs update independently of each other.
    function automatic flags_t flags_merge(input flags_t old_f, input logic nzen,
                                           input logic cven, input flags_t alu_f);
        flags_t res;
        res = old_f;
        if (nzen) begin
            res.n = alu_f.n;
            res.z = alu_f.z;
        end else begin
            res.n = old_f.n;
            res.z = old_f.z;
        end
        if (cven) begin
            res.c = alu_f.c;
            res.v = alu_f.v;
        end else begin
            res.c = old_f.c;
            res.v = old_f.v;
        end
        return res;
    endfunction

endpackage

// File: rtl/branchunit_if.sv
// Execute-stage bundle between decode/ALU (master) and the branch unit (slave).
interface branchunit_if
    import branchunit_pkg::*;
#(
    parameter int unsigned REG_WIDTH = 16
) ();
    logic                 ins_valid;
    logic                 stall;
    logic                 nzen;
    logic                 cven;
    logic                 jmp;
    cond_t                jmpcond;
    logic [REG_WIDTH-1:0] joffset;
    logic                 alu_n;
    logic                 alu_z;
    logic                 alu_c;
    logic                 alu_v;
    logic [REG_WIDTH-1:0] pc;
    flags_t               flags;
    logic                 taken;
    logic                 flush;

    modport master (
        output ins_valid, stall, nzen, cven, jmp, jmpcond, joffset,
               alu_n, alu_z, alu_c, alu_v,
        input  pc, flags, taken, flush
    );

    modport slave (
        input  ins_valid, stall, nzen, cven, jmp, jmpcond, joffset,
               alu_n, alu_z, alu_c, alu_v,
        output pc, flags, taken, flush
    );
endinterface

// File: rtl/branchunit_condeval.sv
// Pure combinational condition evaluator: flags + condition code -> holds.
// Link codes (JSR/RET) never hold here; the branch unit decides those.
module branchunit_condeval
    import branchunit_pkg::*;
(
    input  flags_t flags_i,
    input  cond_t  cond_i,
    output logic   hold_o
);

    // Decode the condition code against the supplied flags.
    always_comb begin
        hold_o = 1'b0;
        case (cond_i)
            COND_AL:  hold_o = 1'b1;
            COND_NV:  hold_o = 1'b0;
            COND_EQ:  hold_o = flags_i.z;
            COND_NE:  hold_o = !flags_i.z;
            COND_CS:  hold_o = flags_i.c;
            COND_CC:  hold_o = !flags_i.c;
            COND_MI:  hold_o = flags_i.n;
            COND_PL:  hold_o = !flags_i.n;
            COND_GE:  hold_o = (flags_i.n == flags_i.v);
            COND_LT:  hold_o = (flags_i.n != flags_i.v);
            COND_GT:  hold_o = !flags_i.z && (flags_i.n == flags_i.v);
            COND_LE:  hold_o = flags_i.z || (flags_i.n != flags_i.v);
            COND_HI:  hold_o = flags_i.c && !flags_i.z;
            COND_LS:  hold_o = !flags_i.c || flags_i.z;
            default:  hold_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branchunit.sv
// Branch unit: owns PC, NZCV flags and the flush pulse for taken jumps.
// Define BRANCHUNIT_LINK_EN to add the link register and JSR/RET codes.
module branchunit
    import branchunit_pkg::*;
#(
    parameter int unsigned          REG_WIDTH = 16,
    parameter logic [REG_WIDTH-1:0] RESET_PC  = {REG_WIDTH{1'b0}}
) (
    input  logic       clk,
    input  logic       rst,
    branchunit_if.slave bus
);

    logic [REG_WIDTH-1:0] pc_q;
    logic [REG_WIDTH-1:0] pc_d;
    flags_t               flags_q;
    flags_t               flags_d;
    logic                 flush_q;
    logic                 flush_d;
    logic                 accept_s;
    logic                 eval_s;
    logic                 cond_hit_s;
    logic                 taken_s;
    flags_t               alu_flags_s;

    assign accept_s    = bus.ins_valid && !bus.stall;
    assign alu_flags_s = '{n: bus.alu_n, z: bus.alu_z, c: bus.alu_c, v: bus.alu_v};

    // Conditions always look at the registered flags, never the ALU inputs.
    branchunit_condeval u_condeval (
        .flags_i (flags_q),
        .cond_i  (bus.jmpcond),
        .hold_o  (eval_s)
    );

`ifdef BRANCHUNIT_LINK_EN
    logic [REG_WIDTH-1:0] link_q;
    logic [REG_WIDTH-1:0] link_d;

    assign cond_hit_s = (bus.jmpcond == COND_JSR) || (bus.jmpcond == COND_RET) || eval_s;

    // Capture the return address on an accepted JSR.
    always_comb begin
        link_d = link_q;
        if (taken_s && (bus.jmpcond == COND_JSR)) begin
            link_d = pc_q + REG_WIDTH'(1);
        end else begin
            link_d = link_q;
        end
    end

    // Link register state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            link_q <= {REG_WIDTH{1'b0}};
        end else begin
            link_q <= link_d;
        end
    end
`else
    assign cond_hit_s = eval_s;
`endif

    assign taken_s = !rst && accept_s && bus.jmp && cond_hit_s;

    // Next PC/flags; sums wrap modulo 2^REG_WIDTH by truncation.
    always_comb begin
        pc_d    = pc_q;
        flags_d = flags_q;
        flush_d = taken_s;
        if (accept_s) begin
            flags_d = flags_merge(flags_q, bus.nzen, bus.cven, alu_flags_s);
            if (taken_s) begin
`ifdef BRANCHUNIT_LINK_EN
                if (bus.jmpcond == COND_RET) begin
                    pc_d = link_q;
                end else begin
                    pc_d = pc_q + bus.joffset;
                end
`else
                pc_d = pc_q + bus.joffset;
`endif
            end else begin
                pc_d = pc_q + REG_WIDTH'(1);
            end
        end else begin
            pc_d    = pc_q;
            flags_d = flags_q;
        end
    end

    // Architectural PC, flags and flush registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            flags_q <= '{n: 1'b0, z: 1'b0, c: 1'b0, v: 1'b0};
            flush_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            flags_q <= flags_d;
            flush_q <= flush_d;
        end
    end

    assign bus.pc    = pc_q;
    assign bus.flags = flags_q;
    assign bus.flush = flush_q;
    assign bus.taken = taken_s;

endmodule

// File: tb/tb_branchunit.sv
// Scoreboard bench for branchunit: directed vectors push expectations,
// a monitor pops and compares one entry per clock.
module tb_branchunit;
    import branchunit_pkg::*;

`ifdef BRANCHUNIT_LINK_EN
    localparam bit LINK = 1'b1;
`else
    localparam bit LINK = 1'b0;
`endif

    typedef struct {
        string       name;
        logic        taken;
        logic [15:0] pc;
        logic [3:0]  flags;
        logic        flush;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb_q[$];
    int   n_pass;
    int   n_total;
    logic taken_smp;

    branchunit_if #(.REG_WIDTH(16)) bus ();

    branchunit #(.REG_WIDTH(16), .RESET_PC(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic step(input string nm, input logic v, input logic st, input logic nz,
                        input logic cv, input logic j, input logic [3:0] cond,
                        input logic [15:0] off, input logic [3:0] alu,
                        input logic et, input logic [15:0] epc, input logic [3:0] ef,
                        input logic efl);
        exp_t e;
        @(negedge clk);
        bus.ins_valid = v;
        bus.stall     = st;
        bus.nzen      = nz;
        bus.cven      = cv;
        bus.jmp       = j;
        bus.jmpcond   = cond_t'(cond);
        bus.joffset   = off;
        bus.alu_n     = alu[3];
        bus.alu_z     = alu[2];
        bus.alu_c     = alu[1];
        bus.alu_v     = alu[0];
        e.name  = nm;
        e.taken = et;
        e.pc    = epc;
        e.flags = ef;
        e.flush = efl;
        sb_q.push_back(e);
    endtask

    // Monitor: taken sampled mid low phase, registered outputs just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2 taken_smp = bus.taken;
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check({e.name, ".taken"}, 32'(taken_smp), 32'(e.taken));
                check({e.name, ".pc"},    32'(bus.pc),    32'(e.pc));
                check({e.name, ".flags"}, 32'(bus.flags), 32'(e.flags));
                check({e.name, ".flush"}, 32'(bus.flush), 32'(e.flush));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst = 1'b1;
        bus.ins_valid = 1'b0; bus.stall = 1'b0; bus.nzen = 1'b0; bus.cven = 1'b0;
        bus.jmp = 1'b0; bus.jmpcond = COND_AL; bus.joffset = 16'h0000;
        bus.alu_n = 1'b0; bus.alu_z = 1'b0; bus.alu_c = 1'b0; bus.alu_v = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.pc",    32'(bus.pc),    32'h0);
        check("rst.flags", 32'(bus.flags), 32'h0);
        check("rst.flush", 32'(bus.flush), 32'h0);
        check("rst.taken", 32'(bus.taken), 32'h0);
        rst = 1'b0;

        //    name        v    st   nz   cv   j    cond   off       alu      t    pc        flags    fl
        step("seq1",     1'b1,1'b0,1'b0,1'b0,1'b0,4'd0, 16'h0000,4'b0000, 1'b0,16'h0001,4'b0000,1'b0);
        step("seq2",     1'b1,1'b0,1'b0,1'b0,1'b0,4'd0, 16'h0000,4'b0000, 1'b0,16'h0002,4'b0000,1'b0);
        step("seq3",     1'b1,1'b0,1'b0,1'b0,1'b0,4'd0, 16'h0000,4'b0000, 1'b0,16'h0003,4'b0000,1'b0);
        step("nz_only",  1'b1,1'b0,1'b1,1'b0,1'b0,4'd0, 16'h0000,4'b1111, 1'b0,16'h0004,4'b1100,1'b0);
        step("cv_only",  1'b1,1'b0,1'b0,1'b1,1'b0,4'd0, 16'h0000,4'b0001, 1'b0,16'h0005,4'b1101,1'b0);
        step("al_to10",  1'b1,1'b0,1'b0,1'b0,1'b1,4'd0, 16'h000B,4'b0000, 1'b1,16'h0010,4'b1101,1'b1);
        step("eq_back",  1'b1,1'b0,1'b0,1'b0,1'b1,4'd2, 16'hFFF8,4'b0000, 1'b1,16'h0008,4'b1101,1'b1);
        step("al_fwd",   1'b1,1'b0,1'b0,1'b0,1'b1,4'd0, 16'h0008,4'b0000, 1'b1,16'h0010,4'b1101,1'b1);
        step("ne_not",   1'b1,1'b0,1'b0,1'b0,1'b1,4'd3, 16'hFFF8,4'b0000, 1'b0,16'h0011,4'b1101,1'b0);
        step("idle",     1'b0,1'b0,1'b1,1'b1,1'b1,4'd0, 16'h0040,4'b0000, 1'b0,16'h0011,4'b1101,1'b0);
        step("to_ffff",  1'b1,1'b0,1'b0,1'b0,1'b1,4'd0, 16'hFFEE,4'b0000, 1'b1,16'hFFFF,4'b1101,1'b1);
        step("wrap",     1'b1,1'b0,1'b0,1'b0,1'b0,4'd0, 16'h0000,4'b0000, 1'b0,16'h0000,4'b1101,1'b0);
        step("stall_j",  1'b1,1'b1,1'b1,1'b1,1'b1,4'd0, 16'h0005,4'b0000, 1'b0,16'h0000,4'b1101,1'b0);
        step("al_to4",   1'b1,1'b0,1'b0,1'b0,1'b1,4'd0, 16'h0004,4'b0000, 1'b1,16'h0004,4'b1101,1'b1);
        step("stall_fl", 1'b1,1'b1,1'b0,1'b0,1'b1,4'd0, 16'h0004,4'b0000, 1'b0,16'h0004,4'b1101,1'b0);
        step("set_n",    1'b1,1'b0,1'b1,1'b1,1'b0,4'd0, 16'h0000,4'b1000, 1'b0,16'h0005,4'b1000,1'b0);
        step("lt_tk",    1'b1,1'b0,1'b0,1'b0,1'b1,4'd9, 16'h0010,4'b0000, 1'b1,16'h0015,4'b1000,1'b1);
        step("ge_not",   1'b1,1'b0,1'b0,1'b0,1'b1,4'd8, 16'h0010,4'b0000, 1'b0,16'h0016,4'b1000,1'b0);
        step("set_v",    1'b1,1'b0,1'b0,1'b1,1'b0,4'd0, 16'h0000,4'b0001, 1'b0,16'h0017,4'b1001,1'b0);
        step("gt_tk",    1'b1,1'b0,1'b0,1'b0,1'b1,4'd10,16'h0009,4'b0000, 1'b1,16'h0020,4'b1001,1'b1);
        step("le_not",   1'b1,1'b0,1'b0,1'b0,1'b1,4'd11,16'h0009,4'b0000, 1'b0,16'h0021,4'b1001,1'b0);
        step("hi_not",   1'b1,1'b0,1'b0,1'b0,1'b1,4'd12,16'h0009,4'b0000, 1'b0,16'h0022,4'b1001,1'b0);
        step("nv_not",   1'b1,1'b0,1'b0,1'b0,1'b1,4'd1, 16'h0009,4'b0000, 1'b0,16'h0023,4'b1001,1'b0);
        step("ls_tk",    1'b1,1'b0,1'b0,1'b0,1'b1,4'd13,16'h00DD,4'b0000, 1'b1,16'h0100,4'b1001,1'b1);
        step("jsr",      1'b1,1'b0,1'b0,1'b0,1'b1,4'd14,16'h0020,4'b0000,
             LINK, LINK ? 16'h0120 : 16'h0101, 4'b1001, LINK);
        step("ret",      1'b1,1'b0,1'b0,1'b0,1'b1,4'd15,16'h0020,4'b0000,
             LINK, LINK ? 16'h0101 : 16'h0102, 4'b1001, LINK);
        step("jmp_nz",   1'b1,1'b0,1'b1,1'b0,1'b1,4'd2, 16'h0010,4'b0100,
             1'b0, LINK ? 16'h0102 : 16'h0103, 4'b0101, 1'b0);
        step("eq_newz",  1'b1,1'b0,1'b0,1'b0,1'b1,4'd2, 16'h0010,4'b0000,
             1'b1, LINK ? 16'h0112 : 16'h0113, 4'b0101, 1'b1);

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        check("sb_drain", 32'(sb_q.size()), 32'h0);

        // Asynchronous reset in the middle of a taken jump with flush still high.
        @(negedge clk);
        bus.ins_valid = 1'b1; bus.stall = 1'b0; bus.jmp = 1'b1;
        bus.jmpcond = COND_AL; bus.joffset = 16'h0010; bus.nzen = 1'b0; bus.cven = 1'b0;
        #3 rst = 1'b1;
        #1;
        check("mid_rst.pc",    32'(bus.pc),    32'h0);
        check("mid_rst.flags", 32'(bus.flags), 32'h0);
        check("mid_rst.flush", 32'(bus.flush), 32'h0);
        check("mid_rst.taken", 32'(bus.taken), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        bus.ins_valid = 1'b0; bus.jmp = 1'b0;
        step("post_rst", 1'b1,1'b0,1'b0,1'b0,1'b0,4'd0, 16'h0000,4'b0000, 1'b0,16'h0001,4'b0000,1'b0);
        step("post_idl", 1'b0,1'b0,1'b0,1'b0,1'b0,4'd0, 16'h0000,4'b0000, 1'b0,16'h0001,4'b0000,1'b0);

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        check("sb_drain2", 32'(sb_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
